access_controller_gen: RTL and testbench

- Parametrised successor to the single-digit access controller.
- Holds a DIGITS-digit password and accepts a digit-serial guess entry.
- Grants access through `enable`/`green_led`; counts failures and enforces a timed lockout after MAX_TRIES misses.
- Sits between the switch/button front end and the game core; `enable` gates the game and `reconfig` notifies it of a password change.

---
 rtl/access_pkg.sv | 45 ++++
 rtl/access_tick_gen.sv | 32 +++
 rtl/access_controller_gen.sv | 219 +++++++++++++++++++++
 tb/tb_access_controller_gen.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/access_pkg.sv
// Shared definitions for the access controller: FSM state encoding, width
// helpers and LFSR tap masks used by the ACCESS_RNG_PW_EN random-password
// build option.
package access_pkg;

   // FSM state encoding
   localparam logic [2:0] S_UNSET   = 3'd0;
   localparam logic [2:0] S_SET_PW  = 3'd1;
   localparam logic [2:0] S_ARMED   = 3'd2;
   localparam logic [2:0] S_ENTRY   = 3'd3;
   localparam logic [2:0] S_GRANTED = 3'd4;
   localparam logic [2:0] S_DENIED  = 3'd5;
   localparam logic [2:0] S_LOCKOUT = 3'd6;

   // Defaults for the 4-digit, 1 s tick build
   localparam int DEF_DIGITS = 4;
   localparam int IDX_W      = $clog2(DEF_DIGITS + 1);
   localparam int CNT_W      = $clog2(30 + 1);

   // Width of a counter that must hold 0..n
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Right-shift Galois toggle masks for maximal-length LFSRs. Widths not in
   // the table get a short-period fallback (still never locks up at zero).
   function automatic logic [63:0] lfsr_taps(input int w);
      case (w)
         4:       return 64'h0000_0000_0000_000C;
         8:       return 64'h0000_0000_0000_00B8;
         12:      return 64'h0000_0000_0000_0E08;
         16:      return 64'h0000_0000_0000_B400;
         24:      return 64'h0000_0000_00E1_0000;
         32:      return 64'h0000_0000_8020_0003;
         default: return (64'd1 << (w - 1)) | 64'd1;
      endcase
   endfunction

endpackage

// File: rtl/access_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks while enabled.
// Held at zero when disabled; clr restarts the period.
module access_tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;

   assign tick = en && (pre_q == LAST);

   // next prescaler value: wrap on tick, restart on clear or when idle
   always_comb begin
      pre_d = pre_q + PW'(1);
      if (clr || !en || pre_q == LAST) pre_d = '0;
   end

   // prescaler register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pre_q <= '0;
      else      pre_q <= pre_d;
   end

endmodule

// File: rtl/access_controller_gen.sv
// Digit-serial password access controller with failure counting and timed
// lockout. Build option ACCESS_RNG_PW_EN adds an LFSR-sourced random
// password loaded by rng_button.
module access_controller_gen
   import access_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int DIGIT_W       = 4,
   parameter int MAX_TRIES     = 3,
   parameter int TICK_DIV      = 50_000_000,
   parameter int ENTRY_TIMEOUT = 10,
   parameter int DENY_TICKS    = 2,
   parameter int LOCKOUT_TICKS = 30
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [DIGIT_W-1:0]                  digit_in,
   input  logic                                load,
   input  logic                                button_push,
   input  logic                                relock,
   input  logic                                rng_button,
   output logic                                enable,
   output logic                                green_led,
   output logic                                red_led,
   output logic                                locked_out,
   output logic                                armed,
   output logic                                reconfig,
   output logic [$clog2(DIGITS+1)-1:0]         digit_idx,
   output logic [$clog2(MAX_TRIES+1)-1:0]      fail_count,
   output logic [DIGITS*DIGIT_W-1:0]           password_out
);

   localparam int PW_W   = DIGITS * DIGIT_W;
   localparam int IW     = $clog2(DIGITS + 1);
   localparam int FW     = $clog2(MAX_TRIES + 1);
   localparam int TW     = cnt_width(max3(ENTRY_TIMEOUT, DENY_TICKS, LOCKOUT_TICKS));

   logic [2:0]         state_q, state_d;
   logic [PW_W-1:0]    pw_q, pw_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [FW-1:0]      fail_q, fail_d;
   logic [TW-1:0]      tcnt_q, tcnt_d;
   logic               mis_q, mis_d;
   logic               from_gr_q, from_gr_d;
   logic               reconf_d;
   logic               push_acc, mis_now, last, tick, tclr, timed;
   logic [DIGIT_W-1:0] exp_dig;
   logic [PW_W-1:0]    rng_pw;

`ifdef ACCESS_RNG_PW_EN
   localparam logic [63:0] TAPS = lfsr_taps(PW_W);
   logic [PW_W-1:0] lfsr_q;

   // free-running LFSR, nonzero seed
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         lfsr_q <= PW_W'(1);
      else if (lfsr_q[0]) lfsr_q <= (lfsr_q >> 1) ^ TAPS[PW_W-1:0];
      else              lfsr_q <= lfsr_q >> 1;
   end
   assign rng_pw = lfsr_q;
`else
   logic unused_rng;
   assign unused_rng = rng_button;
   assign rng_pw     = '0;
`endif

   assign timed = (state_q == S_ENTRY) || (state_q == S_DENIED) || (state_q == S_LOCKOUT);
   assign last  = (idx_q == IW'(DIGITS - 1));

   access_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (timed),
      .clr  (tclr),
      .tick (tick)
   );

   // password digit selected by the current entry position
   always_comb begin
      exp_dig = '0;
      for (int i = 0; i < DIGITS; i++)
         if (idx_q == IW'(i)) exp_dig = pw_q[PW_W-1-i*DIGIT_W -: DIGIT_W];
   end

   // FSM next state, password/guess capture and failure accounting
   always_comb begin
      state_d   = state_q;
      pw_d      = pw_q;
      idx_d     = idx_q;
      fail_d    = fail_q;
      mis_d     = mis_q;
      from_gr_d = from_gr_q;
      reconf_d  = 1'b0;
      push_acc  = 1'b0;
      mis_now   = 1'b0;
      case (state_q)
         S_UNSET, S_GRANTED, S_SET_PW: begin
            if (state_q == S_GRANTED && relock) begin
               state_d = S_ARMED;
            end else if (load) begin
               // idx_q is 0 outside SET_PW, so this always writes the right digit
               for (int i = 0; i < DIGITS; i++)
                  if (idx_q == IW'(i)) pw_d[PW_W-1-i*DIGIT_W -: DIGIT_W] = digit_in;
               if (state_q != S_SET_PW) from_gr_d = (state_q == S_GRANTED);
               if (last) begin
                  state_d   = S_ARMED;
                  idx_d     = '0;
                  reconf_d  = (state_q == S_SET_PW) ? from_gr_q : (state_q == S_GRANTED);
                  from_gr_d = 1'b0;
               end else begin
                  state_d = S_SET_PW;
                  idx_d   = idx_q + IW'(1);
               end
            end else if (rng_button && state_q != S_SET_PW) begin
`ifdef ACCESS_RNG_PW_EN
               pw_d     = rng_pw;
               state_d  = S_ARMED;
               reconf_d = (state_q == S_GRANTED);
`endif
            end
         end
         S_ARMED, S_ENTRY: begin
            if (state_q == S_ENTRY && relock) begin
               state_d = S_ARMED;
               idx_d   = '0;
               mis_d   = 1'b0;
            end else if (button_push) begin
               push_acc = 1'b1;
               mis_now  = (state_q == S_ENTRY && mis_q) || (digit_in != exp_dig);
               if (last) begin
                  idx_d = '0;
                  mis_d = 1'b0;
                  if (!mis_now) begin
                     state_d = S_GRANTED;
                     fail_d  = '0;
                  end else if (fail_q >= FW'(MAX_TRIES - 1)) begin
                     state_d = S_LOCKOUT;
                     fail_d  = FW'(MAX_TRIES);
                  end else begin
                     state_d = S_DENIED;
                     fail_d  = fail_q + FW'(1);
                  end
               end else begin
                  state_d = S_ENTRY;
                  mis_d   = mis_now;
                  if (idx_q != IW'(DIGITS)) idx_d = idx_q + IW'(1);
               end
            end else if (state_q == S_ENTRY && tick && tcnt_q == TW'(ENTRY_TIMEOUT - 1)) begin
               // idle timeout counts as a wrong guess
               idx_d = '0;
               mis_d = 1'b0;
               if (fail_q >= FW'(MAX_TRIES - 1)) begin
                  state_d = S_LOCKOUT;
                  fail_d  = FW'(MAX_TRIES);
               end else begin
                  state_d = S_DENIED;
                  fail_d  = fail_q + FW'(1);
               end
            end
         end
         S_DENIED: begin
            if (tick && tcnt_q == TW'(DENY_TICKS - 1)) state_d = S_ARMED;
         end
         S_LOCKOUT: begin
            if (tick && tcnt_q == TW'(LOCKOUT_TICKS - 1)) begin
               state_d = S_ARMED;
               fail_d  = '0;
            end
         end
         default: state_d = S_UNSET;
      endcase
   end

   // tick count restarts on any state change or accepted guess digit
   always_comb begin
      tclr   = (state_d != state_q) || push_acc;
      tcnt_d = tcnt_q;
      if (tclr)      tcnt_d = '0;
      else if (tick) tcnt_d = tcnt_q + TW'(1);
   end

   // state, data and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_UNSET;
         pw_q       <= '0;
         idx_q      <= '0;
         fail_q     <= '0;
         tcnt_q     <= '0;
         mis_q      <= 1'b0;
         from_gr_q  <= 1'b0;
         enable     <= 1'b0;
         green_led  <= 1'b0;
         red_led    <= 1'b0;
         locked_out <= 1'b0;
         armed      <= 1'b0;
         reconfig   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pw_q       <= pw_d;
         idx_q      <= idx_d;
         fail_q     <= fail_d;
         tcnt_q     <= tcnt_d;
         mis_q      <= mis_d;
         from_gr_q  <= from_gr_d;
         enable     <= (state_d == S_GRANTED);
         green_led  <= (state_d == S_GRANTED);
         red_led    <= (state_d == S_DENIED) || (state_d == S_LOCKOUT);
         locked_out <= (state_d == S_LOCKOUT);
         armed      <= (state_d == S_ARMED);
         reconfig   <= reconf_d;
      end
   end

   assign digit_idx    = idx_q;
   assign fail_count   = fail_q;
   assign password_out = pw_q;

endmodule

// File: tb/tb_access_controller_gen.sv
// Directed bench for access_controller_gen with a 4-clock tick.
module tb_access_controller_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  digit_in = '0;
   logic        load = 1'b0, button_push = 1'b0, relock = 1'b0, rng_button = 1'b0;
   logic        enable, green_led, red_led, locked_out, armed, reconfig;
   logic [2:0]  digit_idx;
   logic [1:0]  fail_count;
   logic [15:0] password_out;

   int total = 0;
   int bad   = 0;

   access_controller_gen #(
      .DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3), .TICK_DIV(4),
      .ENTRY_TIMEOUT(3), .DENY_TICKS(2), .LOCKOUT_TICKS(5)
   ) dut (
      .clk(clk), .rst(rst), .digit_in(digit_in), .load(load),
      .button_push(button_push), .relock(relock), .rng_button(rng_button),
      .enable(enable), .green_led(green_led), .red_led(red_led),
      .locked_out(locked_out), .armed(armed), .reconfig(reconfig),
      .digit_idx(digit_idx), .fail_count(fail_count), .password_out(password_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_load(input logic [3:0] d);
      digit_in = d; load = 1'b1; cyc(1); load = 1'b0;
   endtask

   task automatic do_push(input logic [3:0] d);
      digit_in = d; button_push = 1'b1; cyc(1); button_push = 1'b0;
   endtask

   task automatic do_relock();
      relock = 1'b1; cyc(1); relock = 1'b0;
   endtask

   task automatic guess(input logic [15:0] g);
      do_push(g[15:12]); do_push(g[11:8]); do_push(g[7:4]); do_push(g[3:0]);
   endtask

   function automatic logic [31:0] all_out();
      return {enable, green_led, red_led, locked_out, armed, reconfig,
              digit_idx, fail_count, password_out};
   endfunction

   initial begin
      // reset state
      cyc(2);
      check("reset_outputs", all_out(), 32'h0);
      rst = 1'b1;
      cyc(1);

      // guess strobes are ignored until a password exists
      do_push(4'h1);
      check("unset_push_ignored", {armed, digit_idx}, {1'b0, 3'd0});

      // program 1234
      do_load(4'h1);
      check("load1_idx", {digit_idx, password_out}, {3'd1, 16'h1000});
      do_load(4'h2); do_load(4'h3); do_load(4'h4);
      check("pw_1234", {armed, digit_idx, password_out}, {1'b1, 3'd0, 16'h1234});

      // correct entry
      do_push(4'h1);
      check("entry_first", {armed, digit_idx}, {1'b0, 3'd1});
      do_push(4'h2); do_push(4'h3);
      check("entry_before_last", {enable, green_led, digit_idx}, {1'b0, 1'b0, 3'd3});
      do_push(4'h4);
      check("granted", {enable, green_led, fail_count, digit_idx}, {1'b1, 1'b1, 2'd0, 3'd0});
      do_relock();
      check("relock_granted", {enable, armed}, {1'b0, 1'b1});

      // wrong entry -> DENIED for 8 clocks
      guess(16'h1294);
      check("denied_start", {red_led, fail_count, armed}, {1'b1, 2'd1, 1'b0});
      cyc(7);
      check("denied_held", {red_led, armed}, {1'b1, 1'b0});
      cyc(1);
      check("denied_end", {red_led, armed, fail_count}, {1'b0, 1'b1, 2'd1});

      // two more misses -> LOCKOUT for 20 clocks, strobes ignored
      guess(16'h0000);
      check("second_miss", {red_led, fail_count}, {1'b1, 2'd2});
      cyc(8);
      check("second_deny_end", armed, 1'b1);
      guess(16'h4321);
      check("lockout_start", {locked_out, red_led, fail_count}, {1'b1, 1'b1, 2'd3});
      do_push(4'h1); do_load(4'h5); do_relock();
      check("lockout_strobes", {locked_out, digit_idx, password_out}, {1'b1, 3'd0, 16'h1234});
      cyc(16);
      check("lockout_held", locked_out, 1'b1);
      cyc(1);
      check("lockout_end", {locked_out, red_led, armed, fail_count}, {1'b0, 1'b0, 1'b1, 2'd0});

      // one push then idle -> timeout failure after 12 clocks
      do_push(4'h1);
      cyc(11);
      check("timeout_pending", {red_led, digit_idx}, {1'b0, 3'd1});
      cyc(1);
      check("timeout_fail", {red_led, fail_count, digit_idx}, {1'b1, 2'd1, 3'd0});
      cyc(8);
      check("timeout_deny_end", armed, 1'b1);

      // relock aborts entry and beats a simultaneous push
      do_push(4'h1);
      relock = 1'b1; digit_in = 4'h2; button_push = 1'b1; cyc(1);
      relock = 1'b0; button_push = 1'b0;
      check("relock_entry", {armed, digit_idx, fail_count}, {1'b1, 3'd0, 2'd1});

      // push on the final timeout tick wins; correct entry clears fail_count
      do_push(4'h1);
      cyc(11);
      do_push(4'h2);
      check("push_beats_timeout", {red_led, digit_idx}, {1'b0, 3'd2});
      do_push(4'h3); do_push(4'h4);
      check("granted_clears_fail", {enable, fail_count}, {1'b1, 2'd0});

      // reprogram while granted
      do_load(4'h5);
      check("reprog_first", {enable, digit_idx, reconfig, password_out}, {1'b0, 3'd1, 1'b0, 16'h5234});
      do_load(4'h6); do_load(4'h7);
      check("reprog_mid", reconfig, 1'b0);
      do_load(4'h8);
      check("reprog_done", {reconfig, armed, password_out}, {1'b1, 1'b1, 16'h5678});
      cyc(1);
      check("reconfig_pulse", reconfig, 1'b0);

      // load beats push in GRANTED
      guess(16'h5678);
      digit_in = 4'h9; load = 1'b1; button_push = 1'b1; cyc(1);
      load = 1'b0; button_push = 1'b0;
      check("load_beats_push", {enable, digit_idx, password_out}, {1'b0, 3'd1, 16'h9678});
      do_load(4'h6); do_load(4'h7); do_load(4'h8);
      check("reprog2", {reconfig, password_out}, {1'b1, 16'h9678});

      // reset mid-entry clears everything immediately
      do_push(4'h9);
      #2 rst = 1'b0;
      #1 check("async_reset", all_out(), 32'h0);
      cyc(1);
      rst = 1'b1;
      do_push(4'h9);
      check("post_reset_push", {armed, digit_idx, password_out}, {1'b0, 3'd0, 16'h0});
      do_load(4'h3);
      check("post_reset_load", {digit_idx, password_out}, {3'd1, 16'h3000});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
